// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter.
//   ADDR_W / LEN_W   : widths of the destination address and payload length
//   MAX_LEN          : largest payload a packet may carry
//   INVALID_ADDR     : reserved destination that is rejected at start
//   tx_state_t       : transmitter FSM encoding
//   make_header      : header byte layout {pay_len, dest_addr}
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int LEN_W     = 6;
    localparam int MAX_LEN   = 63;
    localparam int BUF_DEPTH = MAX_LEN + 1;
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                               input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buffer.sv
// Payload staging buffer: 64 x 8 storage with independent write and read
// pointers. Both pointers return to zero on reset and on clr.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous pointer clear (new packet)
//   wr_en/wr_data : append one byte at wr_ptr
//   rd_en       : advance rd_ptr past the byte currently on rd_data
//   wr_ptr      : bytes written so far
//   rd_ptr      : index of the next byte to read
//   rd_data     : byte at rd_ptr (combinational read)
module router_tx_buffer
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [BUF_DEPTH];

    // Storage carries no reset; only the pointers define which bytes are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter. Buffers a payload from upstream, then sends
// header, payload and an XOR parity byte to the router, honouring busy.
//   clk, resetn          : clock, asynchronous active-low reset
//   start, dest_addr, pay_len : packet request (sampled in IDLE)
//   src_valid, src_data, src_ready : upstream payload handshake
//   busy                 : router stall, holds the current output byte
//   packet_valid, data_out : packet byte stream (valid low on parity)
//   tx_active            : FSM not idle
//   done                 : one-cycle pulse after parity consumed
//   cmd_err              : one-cycle pulse on a rejected start
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | waiting for start
// ST_LOAD    | accepting pay_len bytes from upstream
// ST_HEADER  | header byte on data_out
// ST_PAYLOAD | payload byte on data_out
// ST_PARITY  | parity byte on data_out, packet_valid low
// ST_GAP     | done pulse, forced idle cycle between packets
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    input  logic              busy,
    output logic              packet_valid,
    output logic [7:0]        data_out,
    output logic              tx_active,
    output logic              done,
    output logic              cmd_err
);

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        parity_q, parity_d;
    logic [7:0]        data_q, data_d;
    logic              pv_q, pv_d;
    logic              done_q, done_d;
    logic              cmd_err_q, cmd_err_d;

    logic              buf_clr, buf_wr, buf_rd;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [7:0]        rd_data;

    router_tx_buffer u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (src_data),
        .rd_en   (buf_rd),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            parity_q  <= '0;
            data_q    <= '0;
            pv_q      <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            pv_q      <= pv_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        parity_d  = parity_q;
        data_d    = data_q;
        pv_d      = pv_q;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;
        buf_clr   = 1'b0;
        buf_wr    = 1'b0;
        buf_rd    = 1'b0;
        src_ready = (state_q == ST_LOAD);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dest_addr != INVALID_ADDR && pay_len != '0) begin
                        addr_d   = dest_addr;
                        len_d    = pay_len;
                        parity_d = '0;
                        buf_clr  = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (src_valid) begin
                    buf_wr = 1'b1;
                    // wr_ptr still counts bytes before this one, so the last
                    // byte is the one arriving while wr_ptr == len - 1.
                    if (wr_ptr == len_q - LEN_W'(1)) begin
                        data_d   = make_header(len_q, addr_q);
                        parity_d = parity_q ^ make_header(len_q, addr_q);
                        pv_d     = 1'b1;
                        state_d  = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    data_d   = rd_data;
                    parity_d = parity_q ^ rd_data;
                    buf_rd   = 1'b1;
                    state_d  = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!busy) begin
                    // rd_ptr has moved past every byte already placed on
                    // data_out; reaching len means the payload is exhausted.
                    if (rd_ptr == len_q) begin
                        data_d  = parity_q;
                        pv_d    = 1'b0;
                        state_d = ST_PARITY;
                    end else begin
                        data_d   = rd_data;
                        parity_d = parity_q ^ rd_data;
                        buf_rd   = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    data_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign packet_valid = pv_q;
    assign data_out     = data_q;
    assign done         = done_q;
    assign cmd_err      = cmd_err_q;
    assign tx_active    = (state_q != ST_IDLE);

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have start, input, 1, one-cycle request to send a packet.
REQ-004 SHALL have dest_addr, input, 2, destination port 0-2; sampled with start.
REQ-005 SHALL have pay_len, input, 6, payload byte count 1-63; sampled with start.
REQ-006 SHALL have src_valid, input, 1, upstream payload byte valid.
REQ-007 SHALL have src_data, input, 8, upstream payload byte.
REQ-008 SHALL have src_ready, output, 1, block accepts src_data this cycle.
REQ-009 SHALL have busy, input, 1, router stall; byte on data_out not consumed while high.
REQ-010 SHALL have packet_valid, output, 1, high for header and payload bytes, low for parity byte.
REQ-011 SHALL have data_out, output, 8, packet byte to router.
REQ-012 SHALL have tx_active, output, 1, high in any state except IDLE.
REQ-013 SHALL have done, output, 1, one-cycle pulse after parity byte consumed.
REQ-014 SHALL have cmd_err, output, 1, one-cycle pulse on rejected start.

Function
REQ-015 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
REQ-016 IDLE: start with dest_addr!=3 and pay_len!=0 SHALL latch both, clear byte count and parity, go LOAD next edge.
REQ-017 IDLE: start with dest_addr==3 or pay_len==0 SHALL pulse cmd_err next cycle and remain IDLE.
REQ-018 start outside IDLE SHALL be ignored (no cmd_err).
REQ-019 LOAD: src_ready SHALL be 1; each edge with src_valid&src_ready writes src_data to buffer, count+1.
REQ-020 On the edge accepting the pay_len-th byte, SHALL go HEADER, drive packet_valid=1, data_out={pay_len,dest_addr}; src_ready=0 outside LOAD.
REQ-021 A byte SHALL be consumed on each rising edge in HEADER/PAYLOAD/PARITY where busy=0; with busy=1, data_out and packet_valid SHALL hold unchanged.
REQ-022 Header consumed -> PAYLOAD with data_out = buffer byte 0; each consumed payload byte loads the next, in write order, with no gaps or duplicates.
REQ-023 Last payload byte consumed -> PARITY: packet_valid=0, data_out = XOR of header and all payload bytes.
REQ-024 Parity consumed -> GAP: packet_valid=0, data_out=0, done=1 for exactly that cycle; GAP -> IDLE next edge unconditionally.
REQ-025 Minimum one packet_valid-low cycle between packets; back-to-back start earliest in IDLE after GAP.
REQ-026 Parity accumulator SHALL be 8-bit XOR, updated as each byte is loaded onto data_out.

Reset
REQ-027 resetn low SHALL immediately force IDLE, packet_valid=0, data_out=0, src_ready=0, tx_active=0, done=0, cmd_err=0, count/pointers/parity=0, regardless of state.
REQ-028 After resetn release, the first start SHALL behave as REQ-016 with no residue from an aborted packet.

Structure
REQ-029 Shared package router_pkg SHALL hold state enum, ADDR_W=2, LEN_W=6, MAX_LEN=63, INVALID_ADDR=2'b11.
REQ-030 SHALL instantiate one sub-module router_tx_buffer: 64x8 storage, write/read pointers, both cleared on resetn and on entering LOAD.

Verification
REQ-031 addr=1,len=3, payload 11,22,33, busy=0 -> packet_valid=1 bytes 0D,11,22,33; then 0D with packet_valid=0; done next cycle.
REQ-032 Same packet, busy=1 for 3 cycles while 22 on data_out -> 22 held 4 cycles, stream still 0D,11,22,33,0D.
REQ-033 start with addr=3 (then len=0) -> cmd_err one cycle each, src_ready stays 0, state IDLE.
REQ-034 addr=2,len=63, bytes 00..3E with random src_valid gaps -> header FE, 63 bytes in order, parity = FE XOR (00..3E).
REQ-035 resetn pulsed low mid-PAYLOAD -> all outputs 0 asynchronously; subsequent REQ-031 packet correct.
REQ-036 start pulsed during PAYLOAD -> ignored; current packet unaffected, no cmd_err.
